// File: rtl/sha256_pkg.sv
// Shared constants and FSM state encoding for the SHA-256 round controller.
package sha256_pkg;

    localparam int unsigned ROUNDS    = 64;
    localparam int unsigned IDX_W     = 7;
    localparam int unsigned MSG_WORDS = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROUND = 2'd1;
    localparam logic [1:0] ST_FINAL = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/round_constants.sv
// FIPS 180-4 round constant K[t] lookup plus the initial hash value H(0).
module round_constants
    import sha256_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output logic [31:0]      k,
    output logic [255:0]     iv
);

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Indices beyond the last round return zero rather than aliasing.
    assign k  = (idx < IDX_W'(ROUNDS)) ? K_TAB[idx[5:0]] : 32'h0;
    assign iv = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

endmodule

// File: rtl/sha256_round_ctrl.sv
// Sequences one SHA-256 block compression: IV/working-var load, 64 rounds
// (message words for t<16, schedule expansion after), final add, done pulse.
module sha256_round_ctrl
    import sha256_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             first_block,
    input  logic             msg_valid,
    output logic             msg_ready,
    output logic [IDX_W-1:0] round_idx,
    output logic [31:0]      k_t,
    output logic             load_iv,
    output logic             init_work,
    output logic             round_en,
    output logic             use_msg,
    output logic             final_add,
    output logic             busy,
    output logic             done
);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [255:0]     iv_unused;

    // State and round counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        msg_ready = 1'b0;
        use_msg   = 1'b0;
        round_en  = 1'b0;
        load_iv   = 1'b0;
        init_work = 1'b0;
        final_add = 1'b0;
        done      = 1'b0;
        busy      = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                // A start coinciding with reset is dropped.
                if (start && !rst) begin
                    state_d   = ST_ROUND;
                    idx_d     = '0;
                    init_work = 1'b1;
                    load_iv   = first_block;
                end
            end
            ST_ROUND: begin
                if (idx_q < IDX_W'(MSG_WORDS)) begin
                    msg_ready = 1'b1;
                    use_msg   = 1'b1;
                    round_en  = msg_valid;
                end else begin
                    round_en  = 1'b1;
                end
                if (round_en) begin
                    if (idx_q == IDX_W'(ROUNDS - 1)) begin
                        state_d = ST_FINAL;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_FINAL: begin
                final_add = 1'b1;
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign round_idx = idx_q;

    round_constants u_round_constants (
        .idx (idx_q),
        .k   (k_t),
        .iv  (iv_unused)
    );

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Self-checking bench: per-cycle expected trace generated from the block
// protocol (stalls, round count, final/done), compared against the controller.
module tb_sha256_round_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, first_block, msg_valid;
    logic        msg_ready, load_iv, init_work, round_en, use_msg;
    logic        final_add, busy, done;
    logic [6:0]  round_idx;
    logic [31:0] k_t;

    int errors = 0;
    int checks = 0;
    int step_no = 0;

    // Expected flags: {load_iv, init_work, round_en, use_msg, msg_ready, final_add, busy, done}
    typedef struct packed {
        logic       st;
        logic       mv;
        logic       rs;
        logic       chk;
        logic [7:0] flags;
        logic       chk_idx;
        logic [6:0] idx;
    } step_t;

    step_t q[$];

    logic [31:0] ktab [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    sha256_round_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .first_block (first_block),
        .msg_valid   (msg_valid),
        .msg_ready   (msg_ready),
        .round_idx   (round_idx),
        .k_t         (k_t),
        .load_iv     (load_iv),
        .init_work   (init_work),
        .round_en    (round_en),
        .use_msg     (use_msg),
        .final_add   (final_add),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    function automatic step_t mk(input logic st, input logic mv, input logic rs,
                                 input logic chk, input logic [7:0] flags,
                                 input logic chk_idx, input int idx);
        step_t s;
        s.st = st; s.mv = mv; s.rs = rs; s.chk = chk; s.flags = flags;
        s.chk_idx = chk_idx; s.idx = 7'(idx);
        return s;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // mode 0: msg_valid always high; 1: 3-cycle stall at t=5; 2: random stalls/noise.
    task automatic build_block(input logic fb, input int mode, input bit abort40);
        int ns;
        logic noise;
        noise = (mode == 2);
        q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, {fb, 1'b1, 6'b000000}, 1'b0, 0));
        for (int t = 0; t < 64; t++) begin
            if (t < 16) begin
                if (mode == 1)      ns = (t == 5) ? 3 : 0;
                else if (mode == 2) ns = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
                else                ns = 0;
                for (int s = 0; s < ns; s++)
                    q.push_back(mk(noise & rbit(), 1'b0, 1'b0, 1'b1, 8'b00011010, 1'b1, t));
                q.push_back(mk(noise & rbit(), 1'b1, 1'b0, 1'b1, 8'b00111010, 1'b1, t));
            end else if (abort40 && t == 40) begin
                q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, t));
                q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 0));
                q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 0));
                return;
            end else begin
                q.push_back(mk(noise & rbit(), (t == 16) ? 1'b0 : (mode != 2) | rbit(),
                               1'b0, 1'b1, 8'b00100010, 1'b1, t));
            end
        end
        q.push_back(mk(noise & rbit(), rbit(), 1'b0, 1'b1, 8'b00000110, 1'b0, 0));
        q.push_back(mk(noise & rbit(), rbit(), 1'b0, 1'b1, 8'b00000011, 1'b0, 0));
        q.push_back(mk(1'b0, rbit(), 1'b0, 1'b1, 8'h00, 1'b0, 0));
    endtask

    task automatic do_step(input step_t s);
        logic [7:0] obs;
        start = s.st; msg_valid = s.mv; rst = s.rs;
        @(negedge clk);
        obs = {load_iv, init_work, round_en, use_msg, msg_ready, final_add, busy, done};
        if (s.chk) begin
            checks++;
            assert (obs === s.flags) else begin
                errors++;
                $error("FAIL flags step=%0d observed=%b expected=%b", step_no, obs, s.flags);
            end
        end
        if (s.chk_idx) begin
            checks++;
            assert (round_idx === s.idx) else begin
                errors++;
                $error("FAIL round_idx step=%0d observed=%0d expected=%0d", step_no, round_idx, s.idx);
            end
            checks++;
            assert (k_t === ktab[s.idx[5:0]]) else begin
                errors++;
                $error("FAIL k_t step=%0d idx=%0d observed=%h expected=%h", step_no, s.idx, k_t, ktab[s.idx[5:0]]);
            end
        end
        step_no++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_queue();
        while (q.size() > 0) do_step(q.pop_front());
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; first_block = 1'b0; msg_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Reset values, with and without start during reset.
        q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 0));
        q.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 0));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 0));
        run_queue();

        first_block = 1'b1; build_block(1'b1, 0, 1'b0); run_queue();
        first_block = 1'b0; build_block(1'b0, 1, 1'b0); run_queue();
        first_block = 1'b0; build_block(1'b0, 2, 1'b0); run_queue();
        first_block = 1'b1; build_block(1'b1, 2, 1'b1); run_queue();

        // Start together with reset in IDLE must be dropped.
        q.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 0));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 0));
        run_queue();

        first_block = 1'b1; build_block(1'b1, 2, 1'b0); run_queue();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sha256_round_ctrl.md
SHA256_ROUND_CTRL -- requirements
Module: sha256_round_ctrl

Interface
REQ-001 SHALL have no parameters; ROUNDS=64 and IDX_W=7 come from sha256_pkg.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request to compress one 512-bit block; accepted only in IDLE.
REQ-005 first_block  input  1  sampled with accepted start; 1 = load IV into hash state before the rounds.
REQ-006 msg_valid  input  1  message word W[t] valid on datapath input (t<16).
REQ-007 msg_ready  output  1  controller consumes W[t] this cycle if msg_valid.
REQ-008 round_idx  output  7  current round t, 0..63.
REQ-009 k_t  output  32  round constant for round_idx.
REQ-010 load_iv  output  1  one-cycle strobe: hash state H0..H7 <= IV.
REQ-011 init_work  output  1  one-cycle strobe: working vars a..h <= hash state.
REQ-012 round_en  output  1  datapath executes round round_idx this cycle.
REQ-013 use_msg  output  1  1 = datapath takes W from message input, 0 = from schedule expansion.
REQ-014 final_add  output  1  one-cycle strobe: H_i <= H_i + working var_i.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse; digest state valid.

Function
REQ-017 States SHALL be IDLE, ROUND, FINAL, DONE.
REQ-018 IDLE: start=1 -> ROUND; same cycle init_work=1, load_iv=first_block, round_idx counter cleared to 0.
REQ-019 start while busy SHALL be ignored with no effect on state or counter.
REQ-020 ROUND, t<16: msg_ready=1, use_msg=1, round_en=msg_valid; counter holds while msg_valid=0 (stall, unbounded).
REQ-021 ROUND, t>=16: msg_ready=0, use_msg=0, round_en=1 every cycle; msg_valid ignored.
REQ-022 Counter SHALL increment by 1 only on round_en; round_en at t=63 -> FINAL; counter never wraps past 63 within a block.
REQ-023 FINAL: final_add=1 for exactly one cycle -> DONE.
REQ-024 DONE: done=1 for exactly one cycle -> IDLE; start in DONE ignored.
REQ-025 k_t SHALL be combinational from round_idx, valid in every state (k_t=0x428a2f98 when round_idx=0).
REQ-026 Latency with msg_valid held high: start accepted at cycle N, round_en N+1..N+64, final_add N+65, done N+66.
REQ-027 load_iv, init_work, round_en, final_add, done SHALL be mutually exclusive except load_iv with init_work.
REQ-028 Outputs other than k_t SHALL be decoded from registered state and counter plus msg_valid (round_en only).

Reset
REQ-029 rst=1 at any clock edge, including mid-ROUND or FINAL, SHALL force IDLE and counter=0 next cycle; no done or final_add is issued for the aborted block.
REQ-030 Reset values: busy=0, done=0, msg_ready=0, round_en=0, load_iv=0, init_work=0, final_add=0, use_msg=0, round_idx=0.
REQ-031 start asserted together with rst SHALL be ignored.

Structure
REQ-032 sha256_pkg SHALL hold ROUNDS, IDX_W, MSG_WORDS=16 and the state enumeration.
REQ-033 One sub-module SHALL be used: round_constants, driven by round_idx and supplying k_t; its IV output is unused here.
REQ-034 Counter is a 7-bit register.
REQ-035 The FSM is a single 2-bit state register.
REQ-036 Estimated size: 150-250 lines.

Verification
REQ-037 Reset, then start=1, first_block=1, msg_valid=1 constant -> load_iv+init_work at cycle 0, 64 round_en pulses with round_idx 0..63, final_add at cycle 65, done at cycle 66.
REQ-038 msg_valid low for 3 cycles at t=5 -> round_idx holds 5, round_en=0 for those cycles, done 3 cycles later than REQ-037.
REQ-039 Second block with first_block=0 -> init_work=1, load_iv=0; start pulsed during ROUND ignored.
REQ-040 rst asserted at round_idx=40 -> next cycle IDLE, busy=0, round_idx=0, no done.
REQ-041 Sweep round_idx 0..63 -> k_t matches FIPS 180-4 table (t=63 -> 0xc67178f2).
REQ-042 At t=16 msg_valid=0 -> round_en=1 and msg_ready=0 regardless.
